// File: rtl/lc_ctrl_trans_sequencer_if.sv
// Command/OTP/hash handshake bundle between lc_ctrl front end and the transition sequencer.
// Signal names keep lc_ctrl's port naming so the wiring stays traceable at the top level.
interface lc_ctrl_trans_sequencer_if;
    logic       init_done_i;
    logic       trans_cmd_i;
    logic [7:0] fsm_state_o;
    logic       cnt_oflw_err_i;
    logic       trans_invalid_err_i;
    logic       hash_req_o;
    logic       hash_ack_i;
    logic       token_match0_i;
    logic       token_match1_i;
    logic       otp_req_o;
    logic       otp_ack_i;
    logic       otp_err_i;
    logic       busy_o;
    logic       done_o;
    logic       success_o;
    logic [2:0] err_o;

    modport master (
        output init_done_i, trans_cmd_i, cnt_oflw_err_i, trans_invalid_err_i,
        output hash_ack_i, token_match0_i, token_match1_i, otp_ack_i, otp_err_i,
        input  fsm_state_o, hash_req_o, otp_req_o, busy_o, done_o, success_o, err_o
    );

    modport slave (
        input  init_done_i, trans_cmd_i, cnt_oflw_err_i, trans_invalid_err_i,
        input  hash_ack_i, token_match0_i, token_match1_i, otp_ack_i, otp_err_i,
        output fsm_state_o, hash_req_o, otp_req_o, busy_o, done_o, success_o, err_o
    );
endinterface

// File: rtl/lc_ctrl_trans_sequencer.sv
// Single-shot life cycle transition sequencer: counter write, token hash, dual compare, state write.
// Latency: one state per cycle plus OTP/hash ack waits (bounded by TimeoutCycles each).
// Backpressure: level req/ack toward OTP and KMAC; commands outside IdleSt are dropped silently.
module lc_ctrl_trans_sequencer #(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned TimerW        = 11
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    lc_ctrl_trans_sequencer_if.slave  bus
);

    // Sparse codes; ResetSt is all-zero so the exported state reads 0 while in reset.
    typedef enum logic [7:0] {
        ResetSt       = 8'h00,
        IdleSt        = 8'h1E,
        CntIncrSt     = 8'h65,
        CntProgSt     = 8'hB3,
        TransCheckSt  = 8'hC9,
        TokenHashSt   = 8'h5A,
        TokenCheck0St = 8'h96,
        TokenCheck1St = 8'hE8,
        TransProgSt   = 8'h2D,
        PostTransSt   = 8'hF7
    } fsm_state_e;

    localparam logic [2:0] ErrNone    = 3'd0;
    localparam logic [2:0] ErrOflw    = 3'd1;
    localparam logic [2:0] ErrInvalid = 3'd2;
    localparam logic [2:0] ErrToken   = 3'd3;
    localparam logic [2:0] ErrOtp     = 3'd4;
    localparam logic [2:0] ErrTimeout = 3'd5;

    fsm_state_e        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        err_q, err_d, fail_code;
    logic              success_q, success_d;
    logic              done_q, done_d;
    logic              timeout;
    logic              waiting;

    assign timeout = (timer_q == TimerW'(TimeoutCycles - 1));
    assign waiting = (state_q == CntProgSt) || (state_q == TokenHashSt) ||
                     (state_q == TransProgSt);

    always_comb begin
        state_d   = state_q;
        success_d = success_q;
        fail_code = ErrNone;

        // Checks inside each state are ordered by error code so the lowest code wins,
        // and an ack takes precedence over a coincident timeout.
        unique case (state_q)
            ResetSt: begin
                if (bus.init_done_i) state_d = IdleSt;
            end
            IdleSt: begin
                if (bus.trans_cmd_i && bus.init_done_i) state_d = CntIncrSt;
            end
            CntIncrSt: begin
                if (bus.cnt_oflw_err_i) fail_code = ErrOflw;
                else                    state_d   = CntProgSt;
            end
            CntProgSt: begin
                if (bus.otp_ack_i) begin
                    if (bus.otp_err_i) fail_code = ErrOtp;
                    else               state_d   = TransCheckSt;
                end else if (timeout) begin
                    fail_code = ErrTimeout;
                end
            end
            TransCheckSt: begin
                if (bus.trans_invalid_err_i) fail_code = ErrInvalid;
                else                         state_d   = TokenHashSt;
            end
            TokenHashSt: begin
                if (bus.trans_invalid_err_i) fail_code = ErrInvalid;
                else if (bus.hash_ack_i)     state_d   = TokenCheck0St;
                else if (timeout)            fail_code = ErrTimeout;
            end
            TokenCheck0St: begin
                if (bus.trans_invalid_err_i)  fail_code = ErrInvalid;
                else if (!bus.token_match0_i) fail_code = ErrToken;
                else                          state_d   = TokenCheck1St;
            end
            TokenCheck1St: begin
                if (bus.trans_invalid_err_i)  fail_code = ErrInvalid;
                else if (!bus.token_match1_i) fail_code = ErrToken;
                else                          state_d   = TransProgSt;
            end
            TransProgSt: begin
                if (bus.trans_invalid_err_i) begin
                    fail_code = ErrInvalid;
                end else if (bus.otp_ack_i) begin
                    if (bus.otp_err_i) begin
                        fail_code = ErrOtp;
                    end else begin
                        success_d = 1'b1;
                        state_d   = PostTransSt;
                    end
                end else if (timeout) begin
                    fail_code = ErrTimeout;
                end
            end
            PostTransSt: begin
                state_d = PostTransSt;
            end
            default: begin
                fail_code = ErrInvalid;
            end
        endcase

        if (fail_code != ErrNone) state_d = PostTransSt;

        err_d = err_q;
        if ((err_q == ErrNone) && (fail_code != ErrNone)) err_d = fail_code;

        done_d = (state_d == PostTransSt) && (state_q != PostTransSt);

        timer_d = timer_q;
        if (state_d != state_q) timer_d = '0;
        else if (waiting)       timer_d = timer_q + TimerW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ResetSt;
            timer_q   <= '0;
            err_q     <= ErrNone;
            success_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            success_q <= success_d;
            done_q    <= done_d;
        end
    end

    // Requests decode straight from state so they drop on the edge that samples ack or abort.
    assign bus.otp_req_o   = (state_q == CntProgSt) || (state_q == TransProgSt);
    assign bus.hash_req_o  = (state_q == TokenHashSt);
    assign bus.busy_o      = !((state_q == ResetSt) || (state_q == IdleSt) ||
                               (state_q == PostTransSt));
    assign bus.fsm_state_o = state_q;
    assign bus.done_o      = done_q;
    assign bus.success_o   = success_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_lc_ctrl_trans_sequencer.sv
// Directed bench for lc_ctrl_trans_sequencer with auto-responding OTP/hash agents.
module tb_lc_ctrl_trans_sequencer;

    logic clk;
    logic rst_n;

    lc_ctrl_trans_sequencer_if bus ();

    lc_ctrl_trans_sequencer #(
        .TimeoutCycles (1024),
        .TimerW        (11)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Agent configuration, written only by the main initial block.
    bit hash_auto;
    bit otp_err_next;
    int otp_ack_max;

    // Agent state, written only by the responder.
    int otp_acks_total = 0;
    int otp_wait       = 0;
    int hash_wait      = 0;

    always @(negedge clk) begin
        if (bus.otp_req_o && !bus.otp_ack_i && (otp_acks_total < otp_ack_max)) begin
            if (otp_wait == 2) begin
                bus.otp_ack_i = 1'b1;
                bus.otp_err_i = otp_err_next;
                otp_acks_total++;
                otp_wait = 0;
            end else begin
                otp_wait++;
            end
        end else begin
            bus.otp_ack_i = 1'b0;
            bus.otp_err_i = 1'b0;
            otp_wait = 0;
        end
        if (bus.hash_req_o && !bus.hash_ack_i && hash_auto) begin
            if (hash_wait == 2) begin
                bus.hash_ack_i = 1'b1;
                hash_wait = 0;
            end else begin
                hash_wait++;
            end
        end else begin
            bus.hash_ack_i = 1'b0;
            hash_wait = 0;
        end
    end

    // Monitor: request rise counts, done pulses, length of the last OTP request.
    int   otp_rise_cnt  = 0;
    int   hash_rise_cnt = 0;
    int   done_cnt      = 0;
    int   otp_run       = 0;
    int   otp_last_run  = 0;
    logic otp_prev      = 1'b0;
    logic hash_prev     = 1'b0;

    always @(negedge clk) begin
        if (bus.otp_req_o && !otp_prev)   otp_rise_cnt++;
        if (bus.hash_req_o && !hash_prev) hash_rise_cnt++;
        if (bus.done_o)                   done_cnt++;
        if (bus.otp_req_o) begin
            otp_run++;
        end else begin
            if (otp_prev) otp_last_run = otp_run;
            otp_run = 0;
        end
        otp_prev  = bus.otp_req_o;
        hash_prev = bus.hash_req_o;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit idone);
        bus.trans_cmd_i         = 1'b0;
        bus.cnt_oflw_err_i      = 1'b0;
        bus.trans_invalid_err_i = 1'b0;
        bus.token_match0_i      = 1'b1;
        bus.token_match1_i      = 1'b1;
        bus.init_done_i         = 1'b0;
        hash_auto               = 1'b1;
        otp_err_next            = 1'b0;
        otp_ack_max             = 1000000;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        bus.init_done_i = idone;
        step();
        step();
    endtask

    task automatic start_cmd();
        bus.trans_cmd_i = 1'b1;
        step();
        bus.trans_cmd_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.done_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_hash_req(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.hash_req_o) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.init_done_i = 1'b0;
        bus.trans_cmd_i = 1'b0;
        step();
        n_checks++;
        if (bus.fsm_state_o !== 8'h00 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%h busy=%b done=%b expected 00/0/0",
                     bus.fsm_state_o, bus.busy_o, bus.done_o);
        end
        n_checks++;
        if (bus.success_o !== 1'b0 || bus.err_o !== 3'd0 ||
            bus.otp_req_o !== 1'b0 || bus.hash_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: success=%b err=%0d otp_req=%b hash_req=%b expected all 0",
                     bus.success_o, bus.err_o, bus.otp_req_o, bus.hash_req_o);
        end
        do_reset(1'b0);
        start_cmd();
        step();
        step();
        n_checks++;
        if (bus.busy_o !== 1'b0 || bus.fsm_state_o !== 8'h00) begin
            n_fail++;
            $display("FAIL cmd_before_init: busy=%b state=%h expected 0/00",
                     bus.busy_o, bus.fsm_state_o);
        end
    endtask

    task automatic test_happy_path();
        int otp0, hash0, done0;
        bit seen;
        do_reset(1'b1);
        otp0 = otp_rise_cnt; hash0 = hash_rise_cnt; done0 = done_cnt;
        start_cmd();
        n_checks++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL happy_busy: busy=%b expected 1", bus.busy_o);
        end
        wait_done(200, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL happy_done_timeout: done_o not seen within 200 cycles, expected pulse");
        end
        n_checks++;
        if (bus.success_o !== 1'b1 || bus.err_o !== 3'd0) begin
            n_fail++;
            $display("FAIL happy_result: success=%b err=%0d expected 1/0", bus.success_o, bus.err_o);
        end
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (otp_rise_cnt - otp0 != 2 || hash_rise_cnt - hash0 != 1 || done_cnt - done0 != 1) begin
            n_fail++;
            $display("FAIL happy_counts: otp_reqs=%0d hash_reqs=%0d done_pulses=%0d expected 2/1/1",
                     otp_rise_cnt - otp0, hash_rise_cnt - hash0, done_cnt - done0);
        end
        start_cmd();
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (bus.busy_o !== 1'b0 || otp_rise_cnt - otp0 != 2 || bus.success_o !== 1'b1 ||
            done_cnt - done0 != 1) begin
            n_fail++;
            $display("FAIL post_cmd_ignored: busy=%b otp_reqs=%0d success=%b done_pulses=%0d expected 0/2/1/1",
                     bus.busy_o, otp_rise_cnt - otp0, bus.success_o, done_cnt - done0);
        end
    endtask

    task automatic test_overflow();
        int otp0, done0;
        bit seen;
        do_reset(1'b1);
        bus.cnt_oflw_err_i = 1'b1;
        otp0 = otp_rise_cnt; done0 = done_cnt;
        start_cmd();
        wait_done(50, seen);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (!seen || bus.err_o !== 3'd1 || bus.success_o !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_result: done_seen=%b err=%0d success=%b expected 1/1/0",
                     seen, bus.err_o, bus.success_o);
        end
        n_checks++;
        if (otp_rise_cnt - otp0 != 0 || done_cnt - done0 != 1) begin
            n_fail++;
            $display("FAIL overflow_counts: otp_reqs=%0d done_pulses=%0d expected 0/1",
                     otp_rise_cnt - otp0, done_cnt - done0);
        end
        bus.cnt_oflw_err_i = 1'b0;
    endtask

    task automatic test_token_fail();
        int otp0;
        bit seen;
        do_reset(1'b1);
        bus.token_match1_i = 1'b0;
        otp0 = otp_rise_cnt;
        start_cmd();
        wait_done(200, seen);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (!seen || bus.err_o !== 3'd3 || bus.success_o !== 1'b0 || otp_rise_cnt - otp0 != 1) begin
            n_fail++;
            $display("FAIL token_fail: done_seen=%b err=%0d success=%b otp_reqs=%0d expected 1/3/0/1",
                     seen, bus.err_o, bus.success_o, otp_rise_cnt - otp0);
        end
    endtask

    task automatic test_otp_error();
        int otp0, hash0;
        bit seen;
        do_reset(1'b1);
        otp_err_next = 1'b1;
        otp0 = otp_rise_cnt; hash0 = hash_rise_cnt;
        start_cmd();
        wait_done(200, seen);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (!seen || bus.err_o !== 3'd4 || bus.success_o !== 1'b0) begin
            n_fail++;
            $display("FAIL otp_error_result: done_seen=%b err=%0d success=%b expected 1/4/0",
                     seen, bus.err_o, bus.success_o);
        end
        n_checks++;
        if (hash_rise_cnt - hash0 != 0 || otp_rise_cnt - otp0 != 1) begin
            n_fail++;
            $display("FAIL otp_error_counts: hash_reqs=%0d otp_reqs=%0d expected 0/1",
                     hash_rise_cnt - hash0, otp_rise_cnt - otp0);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        do_reset(1'b1);
        otp_ack_max = otp_acks_total + 1;
        start_cmd();
        wait_done(2000, seen);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (!seen || bus.err_o !== 3'd5 || bus.otp_req_o !== 1'b0 || bus.success_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_result: done_seen=%b err=%0d otp_req=%b success=%b expected 1/5/0/0",
                     seen, bus.err_o, bus.otp_req_o, bus.success_o);
        end
        n_checks++;
        if (otp_last_run != 1024) begin
            n_fail++;
            $display("FAIL timeout_length: otp_req held %0d cycles expected 1024", otp_last_run);
        end
    endtask

    task automatic test_invalid_in_hash();
        bit seen;
        do_reset(1'b1);
        hash_auto = 1'b0;
        start_cmd();
        wait_hash_req(50, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL invalid_hash_wait: hash_req_o not seen within 50 cycles, expected 1");
        end
        bus.trans_invalid_err_i = 1'b1;
        step();
        bus.trans_invalid_err_i = 1'b0;
        n_checks++;
        if (bus.err_o !== 3'd2 || bus.hash_req_o !== 1'b0 || bus.done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_in_hash: err=%0d hash_req=%b done=%b expected 2/0/1",
                     bus.err_o, bus.hash_req_o, bus.done_o);
        end
    endtask

    task automatic test_reset_mid_hash();
        bit seen;
        int otp0;
        do_reset(1'b1);
        hash_auto = 1'b0;
        start_cmd();
        wait_hash_req(50, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_reset_wait: hash_req_o not seen within 50 cycles, expected 1");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.hash_req_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.fsm_state_o !== 8'h00 ||
            bus.otp_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: hash_req=%b busy=%b state=%h otp_req=%b expected 0/0/00/0",
                     bus.hash_req_o, bus.busy_o, bus.fsm_state_o, bus.otp_req_o);
        end
        bus.init_done_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        otp0 = otp_rise_cnt;
        start_cmd();
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (bus.busy_o !== 1'b0 || otp_rise_cnt - otp0 != 0) begin
            n_fail++;
            $display("FAIL mid_reset_cmd_dropped: busy=%b otp_reqs=%0d expected 0/0",
                     bus.busy_o, otp_rise_cnt - otp0);
        end
        hash_auto = 1'b1;
        bus.init_done_i = 1'b1;
        step();
        step();
        start_cmd();
        n_checks++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_restart: busy=%b expected 1", bus.busy_o);
        end
        wait_done(200, seen);
        n_checks++;
        if (!seen || bus.success_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: done_seen=%b success=%b expected 1/1", seen, bus.success_o);
        end
    endtask

    initial begin
        rst_n                   = 1'b0;
        hash_auto               = 1'b1;
        otp_err_next            = 1'b0;
        otp_ack_max             = 1000000;
        bus.init_done_i         = 1'b0;
        bus.trans_cmd_i         = 1'b0;
        bus.cnt_oflw_err_i      = 1'b0;
        bus.trans_invalid_err_i = 1'b0;
        bus.token_match0_i      = 1'b1;
        bus.token_match1_i      = 1'b1;

        test_reset();
        test_happy_path();
        test_overflow();
        test_token_fail();
        test_otp_error();
        test_timeout();
        test_invalid_in_hash();
        test_reset_mid_hash();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
